// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: arbiter state encoding,
// default byte width, baud constants and the lock-timeout counter sizing helper.
package uart_pkg;

   // Arbiter FSM encoding
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2,
      HOLD  = 2'd3
   } state_t;

   localparam int DATA_SIZE_DEF = 8;

   // Baud generation constants shared with uart_tx / uart_sampling_tick
   localparam int SYS_FREQ  = 50000000;
   localparam int BAUD_RATE = 115200;
   localparam int SAMPLE    = 16;
   localparam int BAUD_DVSR = 27;

   // Width of a counter able to hold 0..timeout, never narrower than 1 bit
   function automatic int cnt_width(input int timeout);
      int w;
      if (timeout < 1) begin
         w = 1;
      end else begin
         w = $clog2(timeout + 1);
      end
      if (w < 1) begin
         w = 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// Round-robin selector: picks the first asserted request at or above rr_ptr,
// wrapping around. Purely combinational.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    rr_ptr,
   output logic               gnt_valid,
   output logic [ID_W-1:0]    gnt_id
);

   logic [ID_W-1:0] idx_s;

   // Scan offsets from the far end down so the lowest offset from rr_ptr wins
   always_comb begin
      gnt_valid = 1'b0;
      gnt_id    = '0;
      idx_s     = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         idx_s = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
         if (req[idx_s]) begin
            gnt_valid = 1'b1;
            gnt_id    = idx_s;
         end else begin
            gnt_valid = gnt_valid;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx among NUM_REQ byte streams. Round-robin between packets,
// locked to the owner until it sends a last byte or stalls past LOCK_TIMEOUT.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int DATA_SIZE    = DATA_SIZE_DEF,
   parameter int NUM_REQ      = 4,
   parameter int LOCK_TIMEOUT = 4096,
   parameter int ID_W         = $clog2(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_SIZE-1:0]  req_data,
   input  logic [NUM_REQ-1:0]            req_last,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic                          tx_start,
   output logic [DATA_SIZE-1:0]          data_out,
   input  logic                          tx_done_tick,
   output logic                          busy,
   output logic [ID_W-1:0]               grant_id,
   output logic                          pkt_abort
);

   localparam int              CNT_W    = cnt_width(LOCK_TIMEOUT);
   localparam bit              TO_EN    = (LOCK_TIMEOUT > 0);
   localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'((LOCK_TIMEOUT > 0) ? LOCK_TIMEOUT - 1 : 0);
   localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_REQ - 1);

   state_t                state_r;
   state_t                next_state_s;
   logic [ID_W-1:0]       rr_ptr_r;
   logic [CNT_W-1:0]      cnt_r;
   logic                  last_r;

   logic                  gnt_valid_s;
   logic [ID_W-1:0]       gnt_id_s;
   logic [ID_W-1:0]       sel_id_s;
   logic                  capture_s;
   logic                  abort_s;
   logic                  timeout_s;
   logic [ID_W-1:0]       rr_next_s;
   logic [DATA_SIZE-1:0]  sel_data_s;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_rr (
      .req       (req_valid),
      .rr_ptr    (rr_ptr_r),
      .gnt_valid (gnt_valid_s),
      .gnt_id    (gnt_id_s)
   );

   assign busy       = (state_r != IDLE);
   assign timeout_s  = TO_EN && (cnt_r == TO_LIMIT);
   assign rr_next_s  = (grant_id == LAST_ID) ? '0 : grant_id + ID_W'(1);
   assign sel_data_s = req_data[int'(sel_id_s) * DATA_SIZE +: DATA_SIZE];

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state decode
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (gnt_valid_s) begin
               next_state_s = START;
            end else begin
               next_state_s = IDLE;
            end
         end
         START: begin
            next_state_s = WAIT;
         end
         WAIT: begin
            if (tx_done_tick) begin
               next_state_s = last_r ? IDLE : HOLD;
            end else begin
               next_state_s = WAIT;
            end
         end
         HOLD: begin
            if (req_valid[grant_id]) begin
               next_state_s = START;
            end else if (timeout_s) begin
               next_state_s = IDLE;
            end else begin
               next_state_s = HOLD;
            end
         end
         default: begin
            next_state_s = IDLE;
         end
      endcase
   end

   // Handshake, capture select and abort decode; ready is combinational so the
   // transfer lands on the same edge that captures the byte
   always_comb begin
      req_ready = '0;
      capture_s = 1'b0;
      abort_s   = 1'b0;
      sel_id_s  = gnt_id_s;
      case (state_r)
         IDLE: begin
            sel_id_s = gnt_id_s;
            if (gnt_valid_s) begin
               req_ready[gnt_id_s] = 1'b1;
               capture_s           = 1'b1;
            end else begin
               capture_s = 1'b0;
            end
         end
         HOLD: begin
            sel_id_s = grant_id;
            if (req_valid[grant_id]) begin
               req_ready[grant_id] = 1'b1;
               capture_s           = 1'b1;
            end else if (timeout_s) begin
               abort_s = 1'b1;
            end else begin
               abort_s = 1'b0;
            end
         end
         default: begin
            sel_id_s = gnt_id_s;
         end
      endcase
   end

   // Registered outputs, captured byte, round-robin pointer and stall counter
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tx_start  <= 1'b0;
         pkt_abort <= 1'b0;
         data_out  <= '0;
         grant_id  <= '0;
         last_r    <= 1'b0;
         rr_ptr_r  <= '0;
         cnt_r     <= '0;
      end else begin
         tx_start  <= (next_state_s == START);
         pkt_abort <= abort_s;
         if (capture_s) begin
            data_out <= sel_data_s;
            last_r   <= req_last[sel_id_s];
            grant_id <= sel_id_s;
         end
         if ((state_r == WAIT) && tx_done_tick) begin
            cnt_r <= '0;
            if (last_r) begin
               rr_ptr_r <= rr_next_s;
            end
         end else if ((state_r == HOLD) && !req_valid[grant_id]) begin
            cnt_r <= cnt_r + CNT_W'(1);
            if (abort_s) begin
               rr_ptr_r <= rr_next_s;
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter. uart_tx is replaced by a short
// frame model (FRAME cycles from tx_start to tx_done_tick). Bytes are pushed
// to per-requester scoreboards when driven and popped on each tx_start.
module tb_uart_tx_arbiter;

   localparam int DW    = 8;
   localparam int NR    = 4;
   localparam int TO    = 16;
   localparam int IW    = 2;
   localparam int FRAME = 12;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic [NR-1:0]    req_valid;
   logic [NR*DW-1:0] req_data;
   logic [NR-1:0]    req_last;
   logic [NR-1:0]    req_ready;
   logic             tx_start;
   logic [DW-1:0]    data_out;
   logic             tx_done_tick;
   logic             busy;
   logic [IW-1:0]    grant_id;
   logic             pkt_abort;

   typedef struct {
      logic [7:0] data;
      logic       last;
      int         gap;
   } item_t;

   item_t      stim_q [NR][$];
   logic [7:0] exp_q  [NR][$];
   int         exp_id_q[$];

   int tests = 0;
   int fails = 0;
   int hs_cnt [NR];
   int push_cnt [NR];
   int gap_cnt [NR];
   int start_cnt = 0;
   int abort_cnt = 0;
   int abort_at = 0;
   int since_done = 0;
   int frame_cnt = 0;
   logic [7:0]    last_started = 8'h00;
   logic [NR-1:0] xfer_s;
   logic          start_s;

   uart_tx_arbiter #(
      .DATA_SIZE    (DW),
      .NUM_REQ      (NR),
      .LOCK_TIMEOUT (TO),
      .ID_W         (IW)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .req_valid    (req_valid),
      .req_data     (req_data),
      .req_last     (req_last),
      .req_ready    (req_ready),
      .tx_start     (tx_start),
      .data_out     (data_out),
      .tx_done_tick (tx_done_tick),
      .busy         (busy),
      .grant_id     (grant_id),
      .pkt_abort    (pkt_abort)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic push(input int r, input logic [7:0] d, input logic l, input int g);
      item_t it;
      it.data = d;
      it.last = l;
      it.gap  = g;
      stim_q[r].push_back(it);
   endtask

   task automatic clear_sb();
      for (int i = 0; i < NR; i++) begin
         stim_q[i].delete();
         exp_q[i].delete();
         hs_cnt[i]   = 0;
         push_cnt[i] = 0;
      end
      exp_id_q.delete();
      start_cnt = 0;
      abort_cnt = 0;
      abort_at  = 0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      clear_sb();
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic wait_done(input string tag, input int limit);
      int n = 0;
      bit ok = 1'b0;
      while (!ok && n < limit) begin
         @(negedge clk);
         n++;
         ok = 1'b1;
         for (int i = 0; i < NR; i++) begin
            if (stim_q[i].size() != 0 || exp_q[i].size() != 0) ok = 1'b0;
         end
         if (req_valid != '0 || busy || frame_cnt != 0) ok = 1'b0;
      end
      check({tag, "_complete"}, 32'(ok), 32'd1);
      for (int i = 0; i < NR; i++) begin
         check({tag, "_handshakes"}, hs_cnt[i], push_cnt[i]);
      end
   endtask

   // Requester drivers, uart_tx frame model and output monitor
   initial begin : bfm
      item_t it;
      tx_done_tick = 1'b0;
      req_valid    = '0;
      req_data     = '0;
      req_last     = '0;
      for (int i = 0; i < NR; i++) begin
         gap_cnt[i] = 0;
      end
      forever begin
         @(negedge clk);
         xfer_s  = req_valid & req_ready;
         start_s = tx_start;
         if (reset_n) begin
            if (req_ready != '0) check("ready_onehot", $countones(req_ready), 32'd1);
            for (int i = 0; i < NR; i++) begin
               if (req_ready[i]) hs_cnt[i]++;
            end
            if (tx_done_tick) begin
               since_done = 0;
               check("data_hold", data_out, last_started);
            end else if (since_done < 100000) begin
               since_done++;
            end
            if (pkt_abort) begin
               abort_cnt++;
               abort_at = since_done;
            end
            if (tx_start) begin
               start_cnt++;
               last_started = data_out;
               check("ready_in_start", req_ready, 32'd0);
               check("sb_has_byte", 32'(exp_q[grant_id].size() != 0), 32'd1);
               if (exp_q[grant_id].size() != 0) check("sb_data", data_out, exp_q[grant_id].pop_front());
               if (exp_id_q.size() != 0) check("grant_order", grant_id, exp_id_q.pop_front());
            end
         end
         @(posedge clk);
         #1;
         if (!reset_n) begin
            req_valid    = '0;
            tx_done_tick = 1'b0;
            frame_cnt    = 0;
            for (int i = 0; i < NR; i++) gap_cnt[i] = 0;
         end else begin
            tx_done_tick = 1'b0;
            if (frame_cnt != 0) begin
               frame_cnt--;
               if (frame_cnt == 0) tx_done_tick = 1'b1;
            end else if (start_s) begin
               frame_cnt = FRAME;
            end
            for (int i = 0; i < NR; i++) begin
               if (xfer_s[i]) begin
                  req_valid[i] = 1'b0;
                  if (stim_q[i].size() != 0) gap_cnt[i] = stim_q[i][0].gap;
               end
               if (!req_valid[i] && stim_q[i].size() != 0) begin
                  if (gap_cnt[i] == 0) begin
                     it = stim_q[i].pop_front();
                     req_valid[i] = 1'b1;
                     req_data[i*DW +: DW] = it.data;
                     req_last[i] = it.last;
                     exp_q[i].push_back(it.data);
                     push_cnt[i]++;
                  end else begin
                     gap_cnt[i]--;
                  end
               end
            end
         end
      end
   end

   // Scenario sequence
   initial begin : test
      int r;
      int n;
      clear_sb();
      repeat (2) @(negedge clk);
      check("rst_tx_start", tx_start, 32'd0);
      check("rst_data_out", data_out, 32'd0);
      check("rst_grant_id", grant_id, 32'd0);
      check("rst_pkt_abort", pkt_abort, 32'd0);
      check("rst_busy", busy, 32'd0);
      check("rst_req_ready", req_ready, 32'd0);
      reset_n = 1'b1;
      @(negedge clk);

      // single-byte packet, then rr_ptr must have moved to 1
      push(0, 8'hCB, 1'b1, 0);
      exp_id_q.push_back(0);
      wait_done("single", 400);
      check("single_starts", start_cnt, 32'd1);
      check("single_busy", busy, 32'd0);
      push(0, 8'h01, 1'b1, 0);
      push(1, 8'h02, 1'b1, 0);
      exp_id_q.push_back(1);
      exp_id_q.push_back(0);
      wait_done("rr_after_single", 400);

      // round robin across all four, then a second round starting from 0
      do_reset();
      push(0, 8'h11, 1'b1, 0);
      push(1, 8'h22, 1'b1, 0);
      push(2, 8'h33, 1'b1, 0);
      push(3, 8'h44, 1'b1, 0);
      for (int i = 0; i < NR; i++) exp_id_q.push_back(i);
      wait_done("rr_round1", 800);
      push(0, 8'h77, 1'b1, 0);
      push(2, 8'h99, 1'b1, 0);
      exp_id_q.push_back(0);
      exp_id_q.push_back(2);
      wait_done("rr_round2", 400);

      // packet lock holds out a continuously valid requester
      do_reset();
      push(1, 8'hA0, 1'b0, 0);
      push(1, 8'hA1, 1'b0, 0);
      push(1, 8'hA2, 1'b1, 0);
      repeat (2) @(negedge clk);
      push(0, 8'hB0, 1'b1, 0);
      exp_id_q.push_back(1);
      exp_id_q.push_back(1);
      exp_id_q.push_back(1);
      exp_id_q.push_back(0);
      wait_done("lock", 800);

      // stalled lock times out 16 HOLD cycles after tx_done_tick
      do_reset();
      push(2, 8'h55, 1'b0, 0);
      push(3, 8'h66, 1'b1, 0);
      exp_id_q.push_back(2);
      exp_id_q.push_back(3);
      wait_done("timeout", 800);
      check("timeout_aborts", abort_cnt, 32'd1);
      check("timeout_cycle", abort_at, 32'd17);

      // byte arriving on the threshold cycle wins over the abort
      do_reset();
      push(2, 8'h55, 1'b0, 0);
      push(2, 8'h56, 1'b1, FRAME + 17);
      push(3, 8'h66, 1'b1, 0);
      exp_id_q.push_back(2);
      exp_id_q.push_back(2);
      exp_id_q.push_back(3);
      wait_done("edge_no_abort", 800);
      check("edge_aborts", abort_cnt, 32'd0);

      // random stream from two requesters with random gaps
      do_reset();
      for (int k = 0; k < 100; k++) begin
         r = int'($urandom_range(1, 0));
         push(r, 8'($urandom_range(255, 0)), ($urandom_range(3, 0) == 0), int'($urandom_range(20, 0)));
      end
      for (int i = 0; i < 2; i++) begin
         n = stim_q[i].size();
         if (n > 0) stim_q[i][n-1].last = 1'b1;
      end
      wait_done("random", 20000);

      // reset in the middle of a frame
      do_reset();
      push(1, 8'h3C, 1'b1, 0);
      exp_id_q.push_back(1);
      n = 0;
      while (start_cnt == 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("mid_started", start_cnt, 32'd1);
      repeat (4) @(negedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      check("mid_rst_tx_start", tx_start, 32'd0);
      check("mid_rst_busy", busy, 32'd0);
      check("mid_rst_grant_id", grant_id, 32'd0);
      do_reset();
      push(2, 8'h7E, 1'b1, 0);
      exp_id_q.push_back(2);
      wait_done("after_reset", 400);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Overall time bound
   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart_tx instance among NUM_REQ byte-stream requesters using round-robin arbitration with packet lock.
- Once a requester is granted, it keeps the transmitter until it sends a byte flagged last, or until it stalls longer than LOCK_TIMEOUT.
- Drives uart_tx tx_start/data_in and consumes tx_done_tick; sits between per-source TX FIFOs and uart_tx.

Parameters:
- DATA_SIZE, 8, byte width; must match uart_tx DATA_SIZE.
- NUM_REQ, 4, number of requesters (2..16).
- LOCK_TIMEOUT, 4096, clk cycles a locked requester may leave req_valid low between bytes before the lock is dropped; 0 = never drop.
- ID_W, $clog2(NUM_REQ), grant index width.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  requester i has a byte.
- req_data  in  NUM_REQ*DATA_SIZE  requester i's byte is at bits [i*DATA_SIZE +: DATA_SIZE].
- req_last  in  NUM_REQ  byte is the last of its packet.
- req_ready  out  NUM_REQ  one-hot; a transfer occurs on an edge where req_valid[i] & req_ready[i].
- tx_start  out  1  one-cycle start pulse to uart_tx.
- data_out  out  DATA_SIZE  byte to uart_tx data_in; stable from tx_start until tx_done_tick.
- tx_done_tick  in  1  from uart_tx; stop bit finished.
- busy  out  1  state != IDLE.
- grant_id  out  ID_W  current or last owner.
- pkt_abort  out  1  one-cycle pulse when a lock times out.

Behaviour:
- Reset values: tx_start=0, data_out=0, grant_id=0, pkt_abort=0, rr_ptr=0, state=IDLE, timeout counter=0, last_flag=0.
- Reset can assert at any time and returns the block to the reset state immediately. The same reset_n also resets uart_tx, so no partial frame survives.
- States: IDLE, START, WAIT, HOLD.
- IDLE:
  - If any req_valid is set, select the first set bit searching from rr_ptr upward with wrap.
  - req_ready for the selected requester is asserted combinationally in the same cycle.
  - On the edge: capture data_out and last_flag, set grant_id, go to START.
  - If no req_valid is set, stay in IDLE.
- START: tx_start=1 for exactly this cycle, then go to WAIT.
- WAIT:
  - Hold data_out and ignore all requesters.
  - On tx_done_tick: if last_flag=1, set rr_ptr=(grant_id+1) mod NUM_REQ and go to IDLE.
  - Otherwise clear the counter and go to HOLD.
- HOLD (locked to grant_id):
  - If req_valid[grant_id]=1, assert req_ready[grant_id], capture the byte and last, and go to START. Other requesters are never granted while in HOLD.
  - If req_valid[grant_id]=0, increment the counter.
  - If LOCK_TIMEOUT>0 and the counter reaches LOCK_TIMEOUT-1 without a byte arriving: pulse pkt_abort, set rr_ptr=grant_id+1, go to IDLE.
  - A valid byte in the same cycle as the timeout threshold wins: no abort.
- Latency and throughput:
  - IDLE capture edge to tx_start high is 1 cycle.
  - tx_done_tick to the next tx_start on a locked packet is at least 2 cycles (HOLD capture, then START).
  - Back-to-back packets pass through IDLE.
- req_ready is never high in START or WAIT, and at most one bit is high at a time.
- Requesters must hold valid, data and last stable until the transfer edge.
- tx_done_tick seen outside WAIT is ignored.
- A single-byte packet (last=1 on its first byte) releases the lock after that one frame.
- Timeout counter width: $clog2(LOCK_TIMEOUT+1), minimum 1.

Decomposition:
- Shared uart_pkg holds:
  - state encoding localparams (IDLE=0, START=1, WAIT=2, HOLD=3);
  - the default DATA_SIZE;
  - baud constants SYS_FREQ=50000000, BAUD_RATE=115200, SAMPLE=16, BAUD_DVSR=27.
- One combinational sub-module, rr_arbiter (params NUM_REQ, ID_W):
  - inputs req vector and rr_ptr;
  - outputs gnt_valid and gnt_id.
- The FSM, counter and data mux live in uart_tx_arbiter.

Test Plan:
- Run the bench against real uart_tx and uart_sampling_tick at 50 MHz/115200. One 10-bit frame is about 4320 clk.
- Single byte: req 0 sends 0xCB with last=1 -> one tx_start; serial line shows 0xCB LSB-first; busy drops after tx_done_tick; rr_ptr=1.
- Round-robin: all 4 requesters send one last=1 byte each (0x11, 0x22, 0x33, 0x44), valid together -> transmit order 0,1,2,3; the next round with req 0 and req 2 active starts at 0.
- Packet lock: req 1 sends 3 bytes (0xA0, 0xA1, 0xA2 with last on 0xA2) while req 0 is continuously valid -> 0xA0, 0xA1, 0xA2 are contiguous, then req 0 is granted.
- Timeout: LOCK_TIMEOUT=16; req 2 sends 0x55 with last=0 then stalls -> pkt_abort pulses 16 cycles into HOLD; waiting req 3 is granted next. A variant supplies the byte exactly on cycle 16 -> no abort.
- Handshake: 100 random bytes from 2 requesters with random valid gaps -> each req_ready pulses exactly once per byte; the scoreboard byte stream matches the serial output.
- Reset mid-frame: assert reset_n low during WAIT -> tx_start=0, busy=0, grant_id=0 immediately; after release, a fresh request transmits correctly.
